stack_ctrl: RTL

Upstream controller for the 4-deep bidirectional shift-register stack. It accepts single-bit push and pop requests from the host through a ready/request handshake and tracks occupancy. It drives the stack's in/enb/dir inputs one shift per accepted operation and returns the popped bit with a valid strobe. It also flags overflow and underflow attempts.

---
 rtl/stack_pkg.sv | 16 +
 rtl/stack_ctrl_if.sv | 24 ++
 rtl/stack_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/stack_pkg.sv
// Shared definitions for the shift-register stack controller.
// Holds the two-state FSM encoding, the shift-direction codes the stack
// expects on its dir input, and the default stack depth.
package stack_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic DIR_PUSH = 1'b1;
  localparam logic DIR_POP  = 1'b0;

  localparam int DEPTH_DEFAULT = 4;

endpackage

// File: rtl/stack_ctrl_if.sv
// Host-side request/response bundle for stack_ctrl.
// The master (host) raises push_req/pop_req with push_bit and waits for
// req_ready. The slave (controller) answers with req_ready and returns popped
// data as pop_bit qualified by the one-cycle pop_valid strobe.
interface stack_ctrl_if;

  logic push_req;
  logic push_bit;
  logic pop_req;
  logic req_ready;
  logic pop_valid;
  logic pop_bit;

  modport master (
    output push_req, push_bit, pop_req,
    input  req_ready, pop_valid, pop_bit
  );

  modport slave (
    input  push_req, push_bit, pop_req,
    output req_ready, pop_valid, pop_bit
  );

endinterface

// File: rtl/stack_ctrl.sv
// Upstream controller for a DEPTH-deep bidirectional shift-register stack.
// Accepts one push or pop per two cycles from the host, tracks occupancy,
// drives the stack's in/enb/dir pins for one shift per accepted operation,
// returns popped bits, and keeps sticky overflow/underflow flags.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   host              request/response bundle (slave side)
//   clr_err           clears err_ovf/err_unf (a same-cycle new error wins)
//   sr_in/enb/dir     drive the stack's in/enb/dir pins
//   sr_top            current top of stack (stack out3)
//   level             occupancy 0..DEPTH
//   full, empty       decoded from level
//   err_ovf, err_unf  sticky push-while-full / pop-while-empty flags
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  stack_ctrl_if.slave      host,
  input  logic             clr_err,
  output logic             sr_in,
  output logic             sr_enb,
  output logic             sr_dir,
  input  logic             sr_top,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty,
  output logic             err_ovf,
  output logic             err_unf
);

  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);

  state_e           state_q, state_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             sr_enb_q, sr_enb_d;
  logic             sr_dir_q, sr_dir_d;
  logic             sr_in_q, sr_in_d;
  logic             pop_valid_q, pop_valid_d;
  logic             pop_bit_q, pop_bit_d;
  logic             err_ovf_q, err_ovf_d;
  logic             err_unf_q, err_unf_d;
  logic             is_full, is_empty;

  // Occupancy decodes double as the guards that keep level from wrapping.
  assign is_full  = (level_q == LVL_MAX);
  assign is_empty = (level_q == '0);

  // Next-state logic. clr_err is applied first so that an error event in the
  // same cycle overrides it. Push wins a simultaneous request unless the
  // stack is full, in which case the pop is serviced and the push is dropped
  // silently. sr_enb is raised only for the cycle spent in SHIFT.
  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    sr_enb_d    = 1'b0;
    sr_dir_d    = sr_dir_q;
    sr_in_d     = sr_in_q;
    pop_valid_d = 1'b0;
    pop_bit_d   = pop_bit_q;
    err_ovf_d   = clr_err ? 1'b0 : err_ovf_q;
    err_unf_d   = clr_err ? 1'b0 : err_unf_q;

    case (state_q)
      IDLE: begin
        if (host.push_req && !is_full) begin
          sr_dir_d = DIR_PUSH;
          sr_in_d  = host.push_bit;
          sr_enb_d = 1'b1;
          level_d  = level_q + LVL_ONE;
          state_d  = SHIFT;
        end else if (host.pop_req) begin
          if (!is_empty) begin
            pop_bit_d   = sr_top;
            pop_valid_d = 1'b1;
            sr_dir_d    = DIR_POP;
            sr_enb_d    = 1'b1;
            level_d     = level_q - LVL_ONE;
            state_d     = SHIFT;
          end else begin
            err_unf_d = 1'b1;
          end
        end else if (host.push_req) begin
          err_ovf_d = 1'b1;
        end
      end
      SHIFT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs. Reset returns everything, including an
  // in-flight SHIFT, to idle; the stack itself is cleared by the same reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      level_q     <= '0;
      sr_enb_q    <= 1'b0;
      sr_dir_q    <= 1'b0;
      sr_in_q     <= 1'b0;
      pop_valid_q <= 1'b0;
      pop_bit_q   <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_unf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      sr_enb_q    <= sr_enb_d;
      sr_dir_q    <= sr_dir_d;
      sr_in_q     <= sr_in_d;
      pop_valid_q <= pop_valid_d;
      pop_bit_q   <= pop_bit_d;
      err_ovf_q   <= err_ovf_d;
      err_unf_q   <= err_unf_d;
    end
  end

  assign host.req_ready = (state_q == IDLE);
  assign host.pop_valid = pop_valid_q;
  assign host.pop_bit   = pop_bit_q;
  assign sr_in          = sr_in_q;
  assign sr_enb         = sr_enb_q;
  assign sr_dir         = sr_dir_q;
  assign level          = level_q;
  assign full           = is_full;
  assign empty          = is_empty;
  assign err_ovf        = err_ovf_q;
  assign err_unf        = err_unf_q;

endmodule
